axi_ram_slave: RTL

AXI4 slave memory responder: the far end of the system's DDR AXI master port. It accepts single-ID AXI4 read and write bursts, serves them from an internal word-addressed RAM, and generates B and R responses. It stands in for the MIG/DDR controller in simulation and in SRAM-only FPGA builds, connecting directly to the m_axi_* ports of the system top.

---
 rtl/axi_ram_slave_if.sv | 82 ++++++++
 rtl/axi_ram_slave.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/axi_ram_slave_if.sv
// AXI4 bus bundle between the system's DDR AXI master port and axi_ram_slave.
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where both valid and ready are 1. Once valid is raised, its payload stays
// stable until that edge. A slave ready never depends on the same channel's
// valid in the same cycle.
interface axi_ram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // AW channel
  logic              s_axi_awid;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic [7:0]        s_axi_awlen;
  logic [2:0]        s_axi_awsize;
  logic [1:0]        s_axi_awburst;
  logic              s_axi_awlock;
  logic [3:0]        s_axi_awcache;
  logic [2:0]        s_axi_awprot;
  logic [3:0]        s_axi_awqos;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  // W channel
  logic [DATA_W-1:0]   s_axi_wdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic                s_axi_wlast;
  logic                s_axi_wvalid;
  logic                s_axi_wready;
  // B channel
  logic       s_axi_bid;
  logic [1:0] s_axi_bresp;
  logic       s_axi_bvalid;
  logic       s_axi_bready;
  // AR channel
  logic              s_axi_arid;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [7:0]        s_axi_arlen;
  logic [2:0]        s_axi_arsize;
  logic [1:0]        s_axi_arburst;
  logic              s_axi_arlock;
  logic [3:0]        s_axi_arcache;
  logic [2:0]        s_axi_arprot;
  logic [3:0]        s_axi_arqos;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  // R channel
  logic              s_axi_rid;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast;
  logic              s_axi_rvalid;
  logic              s_axi_rready;

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
           s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
           s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI4 slave backed by a word-addressed dual-port RAM. The write engine
// (AW/W/B) and the read engine (AR/R) are independent three-state FSMs. Only
// FIXED and INCR bursts of full bus width are served. Anything else is
// answered with SLVERR, and the RAM is left untouched.
module axi_ram_slave #(
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rstn,
  axi_ram_slave_if.slave    s_axi,
  output logic [1:0]        o_wr_state,
  output logic [1:0]        o_rd_state
);
  localparam int B      = $clog2(DATA_W / 8);
  localparam int DEPTH  = 1 << MEM_ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rd_state_e;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_live;

  wr_state_e             r_wr_state, w_wr_next;
  logic                  r_awid, r_w_fixed, r_w_err;
  logic [MEM_ADDR_W-1:0] r_w_idx;
  logic [7:0]            r_w_len, r_w_cnt;
  logic                  w_aw_hs, w_w_hs, w_w_end, w_aw_bad;

  rd_state_e             r_rd_state, w_rd_next;
  logic                  r_arid, r_r_fixed, r_r_err;
  logic [MEM_ADDR_W-1:0] r_r_idx;
  logic [7:0]            r_r_len, r_r_cnt;
  logic [DATA_W-1:0]     r_ram_q;
  logic                  w_ar_hs, w_r_hs, w_r_last, w_ar_bad;

  assign o_wr_state = r_wr_state;
  assign o_rd_state = r_rd_state;

  assign w_aw_hs  = s_axi.s_axi_awvalid && s_axi.s_axi_awready;
  assign w_w_hs   = s_axi.s_axi_wvalid && s_axi.s_axi_wready;
  assign w_w_end  = s_axi.s_axi_wlast || (r_w_cnt == r_w_len);
  assign w_aw_bad = (s_axi.s_axi_awsize != 3'(B)) || s_axi.s_axi_awburst[1];
  assign w_ar_hs  = s_axi.s_axi_arvalid && s_axi.s_axi_arready;
  assign w_r_hs   = s_axi.s_axi_rvalid && s_axi.s_axi_rready;
  assign w_r_last = (r_r_cnt == r_r_len);
  assign w_ar_bad = (s_axi.s_axi_arsize != 3'(B)) || s_axi.s_axi_arburst[1];

  // Hold both address readies low until the first edge after reset release
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_live <= 1'b0;
    else       r_live <= 1'b1;
  end

  // Write FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_wr_state <= W_IDLE;
    else       r_wr_state <= w_wr_next;
  end

  // Write FSM next state and AW/W/B outputs
  always_comb begin
    w_wr_next           = r_wr_state;
    s_axi.s_axi_awready = 1'b0;
    s_axi.s_axi_wready  = 1'b0;
    s_axi.s_axi_bvalid  = 1'b0;
    s_axi.s_axi_bid     = r_awid;
    s_axi.s_axi_bresp   = 2'b00;
    case (r_wr_state)
      W_IDLE: begin
        s_axi.s_axi_awready = r_live;
        if (s_axi.s_axi_awvalid && r_live) w_wr_next = W_DATA;
      end
      W_DATA: begin
        s_axi.s_axi_wready = 1'b1;
        if (s_axi.s_axi_wvalid && w_w_end) w_wr_next = W_RESP;
      end
      W_RESP: begin
        s_axi.s_axi_bvalid = 1'b1;
        s_axi.s_axi_bresp  = r_w_err ? 2'b10 : 2'b00;
        if (s_axi.s_axi_bready) w_wr_next = W_IDLE;
      end
      default: w_wr_next = W_IDLE;
    endcase
  end

  // Write burst context: latched on AW, stepped per accepted W beat
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_awid    <= 1'b0;
      r_w_idx   <= '0;
      r_w_len   <= '0;
      r_w_cnt   <= '0;
      r_w_fixed <= 1'b0;
      r_w_err   <= 1'b0;
    end else if (w_aw_hs) begin
      r_awid    <= s_axi.s_axi_awid;
      r_w_idx   <= s_axi.s_axi_awaddr[MEM_ADDR_W+B-1:B];
      r_w_len   <= s_axi.s_axi_awlen;
      r_w_cnt   <= '0;
      r_w_fixed <= (s_axi.s_axi_awburst == 2'b00);
      r_w_err   <= w_aw_bad;
    end else if (w_w_hs) begin
      if (!r_w_fixed) r_w_idx <= r_w_idx + 1'b1;
      if (!w_w_end)   r_w_cnt <= r_w_cnt + 8'd1;
      if (s_axi.s_axi_wlast != (r_w_cnt == r_w_len)) r_w_err <= 1'b1;
    end
  end

  // RAM write port (byte enables) and synchronous read port; the read
  // register only loads in R_FETCH so rdata holds while the master stalls
  always_ff @(posedge clk) begin
    if (w_w_hs && !r_w_err) begin
      for (int j = 0; j < NBYTES; j++) begin
        if (s_axi.s_axi_wstrb[j]) r_mem[r_w_idx][8*j +: 8] <= s_axi.s_axi_wdata[8*j +: 8];
      end
    end
    if (r_rd_state == R_FETCH) r_ram_q <= r_mem[r_r_idx];
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rd_state <= R_IDLE;
    else       r_rd_state <= w_rd_next;
  end

  // Read FSM next state and AR/R outputs
  always_comb begin
    w_rd_next           = r_rd_state;
    s_axi.s_axi_arready = 1'b0;
    s_axi.s_axi_rvalid  = 1'b0;
    s_axi.s_axi_rid     = r_arid;
    s_axi.s_axi_rdata   = '0;
    s_axi.s_axi_rresp   = 2'b00;
    s_axi.s_axi_rlast   = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        s_axi.s_axi_arready = r_live;
        if (s_axi.s_axi_arvalid && r_live) w_rd_next = R_FETCH;
      end
      R_FETCH: w_rd_next = R_DATA;
      R_DATA: begin
        s_axi.s_axi_rvalid = 1'b1;
        s_axi.s_axi_rdata  = r_r_err ? '0 : r_ram_q;
        s_axi.s_axi_rresp  = r_r_err ? 2'b10 : 2'b00;
        s_axi.s_axi_rlast  = w_r_last;
        if (s_axi.s_axi_rready) w_rd_next = w_r_last ? R_IDLE : R_FETCH;
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  // Read burst context: latched on AR, stepped per non-final R handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_arid    <= 1'b0;
      r_r_idx   <= '0;
      r_r_len   <= '0;
      r_r_cnt   <= '0;
      r_r_fixed <= 1'b0;
      r_r_err   <= 1'b0;
    end else if (w_ar_hs) begin
      r_arid    <= s_axi.s_axi_arid;
      r_r_idx   <= s_axi.s_axi_araddr[MEM_ADDR_W+B-1:B];
      r_r_len   <= s_axi.s_axi_arlen;
      r_r_cnt   <= '0;
      r_r_fixed <= (s_axi.s_axi_arburst == 2'b00);
      r_r_err   <= w_ar_bad;
    end else if (w_r_hs && !w_r_last) begin
      if (!r_r_fixed) r_r_idx <= r_r_idx + 1'b1;
      r_r_cnt <= r_r_cnt + 8'd1;
    end
  end
endmodule
